// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter, receiver and TX FIFO.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-wide AXI-stream link used on both sides of the UART TX FIFO.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  uart_byte_t tdata;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the core and the UART transmitter; the head byte stays
// stable until the transmitter handshakes it at the end of its frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  uart_tx_fifo_if.slave          S_axis,
  uart_tx_fifo_if.master         M_axis,
  input  logic                   Flush,
  output logic [$clog2(DEPTH):0] Count,
  output logic                   Empty,
  output logic                   Full,
  output logic                   Almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  uart_byte_t    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          wr_en;
  logic          rd_en;
  logic          flush_en;

  // Status comes only from registered pointers; the wrap bit separates full from empty.
  assign Count       = wr_ptr - rd_ptr;
  assign Empty       = (wr_ptr == rd_ptr);
  assign Full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign Almost_full = (Count >= PW'(ALMOST_FULL_LVL));

  assign S_axis.tready = !Full && !Flush;
  assign M_axis.tvalid = !Empty;
  assign M_axis.tdata  = mem[rd_ptr[AW-1:0]];

  assign wr_en    = S_axis.tvalid && S_axis.tready;
  assign rd_en    = M_axis.tvalid && M_axis.tready;
  assign flush_en = Flush && !Empty;

  // Flush keeps the head entry so a frame already on the wire is not disturbed.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= S_axis.tdata;
      if (flush_en) begin
        wr_ptr <= rd_ptr + PW'(1);
        if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk    = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst_n  = 1'b0;
  logic          flush  = 1'b0;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;

  int vectors     = 0;
  int miscompares = 0;

  uart_byte_t q[$];

  uart_tx_fifo_if s_if ();
  uart_tx_fifo_if m_if ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL_LVL(AFL)) dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .S_axis     (s_if),
    .M_axis     (m_if),
    .Flush      (flush),
    .Count      (count),
    .Empty      (empty),
    .Full       (full),
    .Almost_full(almost_full)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of bytes, updated from the inputs seen at each edge.
  always @(posedge clk) begin
    bit rd;
    bit wr;
    uart_byte_t head;
    if (rst_n) begin
      rd = (q.size() != 0) && m_if.tready;
      wr = s_if.tvalid && (q.size() != DEPTH) && !flush;
      if (flush && q.size() != 0) begin
        head = q[0];
        q.delete();
        if (!rd) q.push_back(head);
      end else begin
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(s_if.tdata);
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = q.size();
    chk("m_tvalid", int'(m_if.tvalid), int'(n != 0));
    if (n != 0) chk("m_tdata", int'(m_if.tdata), int'(q[0]));
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == DEPTH));
    chk("almost_full", int'(almost_full), int'(n >= AFL));
    chk("s_tready", int'(s_if.tready), int'((n != DEPTH) && !flush));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input uart_byte_t b);
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    step();
    s_if.tvalid = 1'b0;
  endtask

  initial begin
    uart_byte_t exp_order[3];
    uart_byte_t got[$];
    int sent;
    int cyc;
    bit acc;

    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;

    // Reset with the clock stopped
    #20;
    chk("rst_empty", int'(empty), 1);
    chk("rst_s_tready", int'(s_if.tready), 1);
    chk("rst_m_tvalid", int'(m_if.tvalid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_m_tdata", int'(m_if.tdata), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_full", int'(almost_full), 0);
    #3 rst_n = 1'b1;
    clk_en = 1'b1;
    step();
    step();

    // Ordering, with the head held while the transmitter is busy
    exp_order[0] = 8'hA5;
    exp_order[1] = 8'h5A;
    exp_order[2] = 8'hFF;
    for (int i = 0; i < 3; i++) push(exp_order[i]);
    chk("order_count", int'(count), 3);
    repeat (50) step();
    chk("order_hold", int'(m_if.tdata), 8'hA5);
    for (int i = 0; i < 3; i++) begin
      chk("order_out", int'(m_if.tdata), int'(exp_order[i]));
      m_if.tready = 1'b1;
      step();
      m_if.tready = 1'b0;
    end
    chk("order_empty", int'(empty), 1);

    // Fill to full, then read and write on the same edge
    for (int i = 0; i < DEPTH; i++) begin
      push(uart_byte_t'(8'h30 + i));
      chk("af_level", int'(almost_full), int'(i >= 11));
    end
    chk("full_flag", int'(full), 1);
    chk("full_tready", int'(s_if.tready), 0);
    s_if.tdata  = 8'h99;
    s_if.tvalid = 1'b1;
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    chk("full_rw_count", int'(count), 15);
    chk("full_rw_head", int'(m_if.tdata), 8'h31);
    step();
    s_if.tvalid = 1'b0;
    chk("full_17th_stored", int'(count), 16);
    m_if.tready = 1'b1;
    repeat (20) step();
    m_if.tready = 1'b0;
    chk("full_drained", int'(empty), 1);

    // Wrap: stream 0x00..0x27 under random handshakes
    sent = 0;
    cyc  = 0;
    while ((sent < 40 || got.size() < 40) && cyc < 2000) begin
      s_if.tvalid = (sent < 40) && ($urandom_range(0, 2) != 0);
      s_if.tdata  = uart_byte_t'(sent);
      m_if.tready = $urandom_range(0, 1) != 0;
      #1;
      acc = s_if.tvalid && s_if.tready;
      if (m_if.tvalid && m_if.tready) got.push_back(m_if.tdata);
      step();
      if (acc) sent++;
      chk("wrap_count_bound", int'(count <= CW'(DEPTH)), 1);
      cyc++;
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    chk("wrap_received", got.size(), 40);
    for (int i = 0; i < got.size() && i < 40; i++) chk("wrap_seq", int'(got[i]), i);

    // Flush keeps the head when the transmitter is busy
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    push(8'h55);
    flush = 1'b1;
    #1;
    chk("flush_tready_low", int'(s_if.tready), 0);
    step();
    flush = 1'b0;
    chk("flush_count", int'(count), 1);
    chk("flush_head", int'(m_if.tdata), 8'h11);
    push(8'h22);
    push(8'h33);
    flush       = 1'b1;
    m_if.tready = 1'b1;
    step();
    flush       = 1'b0;
    m_if.tready = 1'b0;
    chk("flush_rd_count", int'(count), 0);
    push(8'h66);
    push(8'h77);
    flush       = 1'b1;
    s_if.tdata  = 8'hEE;
    s_if.tvalid = 1'b1;
    step();
    flush       = 1'b0;
    s_if.tvalid = 1'b0;
    chk("flush_wr_count", int'(count), 1);
    chk("flush_wr_head", int'(m_if.tdata), 8'h66);
    m_if.tready = 1'b1;
    step();
    m_if.tready = 1'b0;
    chk("flush_wr_dropped", int'(count), 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_empty_noop", int'(count), 0);

    // Reset in the middle of a cycle with data queued
    for (int i = 0; i < 8; i++) push(uart_byte_t'(8'hC0 + i));
    chk("midrst_pre_count", int'(count), 8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_m_tvalid", int'(m_if.tvalid), 0);
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_s_tready", int'(s_if.tready), 1);
    chk("midrst_m_tdata", int'(m_if.tdata), 0);
    #10 rst_n = 1'b1;
    step();

    // Random traffic including occasional flushes
    for (int i = 0; i < 400; i++) begin
      s_if.tvalid = $urandom_range(0, 1) != 0;
      s_if.tdata  = uart_byte_t'($urandom_range(0, 255));
      m_if.tready = $urandom_range(0, 2) == 0;
      flush       = $urandom_range(0, 19) == 0;
      step();
    end
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    flush       = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
